// File: rtl/sram2rw_arbiter_if.sv
// Request/response bus and SRAM macro pin bundle for sram2rw_arbiter.
// The arbiter connects through the slave modport; the requester/macro side uses master.
interface sram2rw_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 24
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ*DATA_W-1:0] rsp_rdata;

  logic                   sram_csb1;
  logic                   sram_csb2;
  logic                   sram_web1;
  logic                   sram_web2;
  logic                   sram_oeb1;
  logic                   sram_oeb2;
  logic [ADDR_W-1:0]      sram_a1;
  logic [ADDR_W-1:0]      sram_a2;
  logic [DATA_W-1:0]      sram_i1;
  logic [DATA_W-1:0]      sram_i2;
  logic [DATA_W-1:0]      sram_o1;
  logic [DATA_W-1:0]      sram_o2;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sram_o1, sram_o2,
    output req_ready, rsp_valid, rsp_rdata,
    output sram_csb1, sram_csb2, sram_web1, sram_web2, sram_oeb1, sram_oeb2,
    output sram_a1, sram_a2, sram_i1, sram_i2
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, sram_o1, sram_o2,
    input  req_ready, rsp_valid, rsp_rdata,
    input  sram_csb1, sram_csb2, sram_web1, sram_web2, sram_oeb1, sram_oeb2,
    input  sram_a1, sram_a2, sram_i1, sram_i2
  );
endinterface

// File: rtl/sram2rw_arbiter.sv
// Round-robin arbiter sharing one 2RW SRAM macro between NREQ requesters.
// Up to two non-conflicting grants per cycle (one per macro port); commands are
// registered onto the macro pins and read data is routed back two edges later.
module sram2rw_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 24
) (
  input logic               clock,
  input logic               reset_n,
  sram2rw_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NREQ);

  // Next round-robin index, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] res;
    if (idx == IDX_W'(NREQ - 1)) begin
      res = '0;
    end else begin
      res = idx + 1'b1;
    end
    return res;
  endfunction

  // Two accesses collide when they hit the same word and either one writes.
  function automatic logic is_conflict(input logic [ADDR_W-1:0] addr_x,
                                       input logic [ADDR_W-1:0] addr_y,
                                       input logic              we_x,
                                       input logic              we_y);
    return (addr_x == addr_y) && (we_x || we_y);
  endfunction

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_s     [NREQ];
  logic [DATA_W-1:0] wdata_s    [NREQ];
  logic [IDX_W-1:0]  scan_idx_s [NREQ];
  logic              gnt1_s, gnt2_s;
  logic [IDX_W-1:0]  idx1_s, idx2_s;
  logic [NREQ-1:0]   ready_s;
  logic [1:0]        gnt_s;
  logic [IDX_W-1:0]  gidx_s     [2];

  // Issue stage (index 0 = macro port 1, index 1 = macro port 2)
  logic [1:0]        csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
  logic [1:0]        iv_q, iv_d, ird_q, ird_d;
  logic [ADDR_W-1:0] a_q   [2];
  logic [ADDR_W-1:0] a_d   [2];
  logic [DATA_W-1:0] i_q   [2];
  logic [DATA_W-1:0] i_d   [2];
  logic [IDX_W-1:0]  iid_q [2];
  logic [IDX_W-1:0]  iid_d [2];

  // Response stage
  logic [1:0]        rv_q, rrd_q;
  logic [IDX_W-1:0]  rid_q [2];

  logic [DATA_W-1:0]      sram_o_s    [2];
  logic [DATA_W-1:0]      rdata_arr_s [NREQ];
  logic [NREQ-1:0]        rsp_valid_s;
  logic [NREQ*DATA_W-1:0] rsp_rdata_s;

  assign sram_o_s[0] = bus.sram_o1;
  assign sram_o_s[1] = bus.sram_o2;

  // Unpack the flat request buses and build the scan order starting at ptr.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_s[i]     = bus.req_addr[i*ADDR_W +: ADDR_W];
      wdata_s[i]    = bus.req_wdata[i*DATA_W +: DATA_W];
      scan_idx_s[i] = IDX_W'((int'(ptr_q) + i) % NREQ);
    end
  end

  // Scan from ptr: first valid wins port 1, next non-conflicting valid wins port 2.
  always_comb begin
    gnt1_s  = 1'b0;
    gnt2_s  = 1'b0;
    idx1_s  = '0;
    idx2_s  = '0;
    ready_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_valid[scan_idx_s[k]]) begin
        if (!gnt1_s) begin
          gnt1_s = 1'b1;
          idx1_s = scan_idx_s[k];
        end else if (!gnt2_s &&
                     !is_conflict(addr_s[scan_idx_s[k]], addr_s[idx1_s],
                                  bus.req_we[scan_idx_s[k]], bus.req_we[idx1_s])) begin
          gnt2_s = 1'b1;
          idx2_s = scan_idx_s[k];
        end else begin
        end
      end else begin
      end
    end
    if (gnt1_s) begin
      ready_s[idx1_s] = 1'b1;
    end else begin
    end
    if (gnt2_s) begin
      ready_s[idx2_s] = 1'b1;
    end else begin
    end
  end

  assign bus.req_ready = reset_n ? ready_s : '0;
  assign gnt_s         = {gnt2_s, gnt1_s};
  assign gidx_s[0]     = idx1_s;
  assign gidx_s[1]     = idx2_s;

  // Pointer moves just past the last requester granted this cycle; holds when idle.
  always_comb begin
    if (gnt2_s) begin
      ptr_d = wrap_inc(idx2_s);
    end else if (gnt1_s) begin
      ptr_d = wrap_inc(idx1_s);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Per-port command decode; A and I hold when the port idles (I also holds on reads).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      csb_d[p] = 1'b1;
      web_d[p] = 1'b1;
      oeb_d[p] = 1'b1;
      a_d[p]   = a_q[p];
      i_d[p]   = i_q[p];
      iv_d[p]  = gnt_s[p];
      ird_d[p] = 1'b0;
      iid_d[p] = iid_q[p];
      if (gnt_s[p]) begin
        csb_d[p] = 1'b0;
        a_d[p]   = addr_s[gidx_s[p]];
        iid_d[p] = gidx_s[p];
        if (bus.req_we[gidx_s[p]]) begin
          web_d[p] = 1'b0;
          i_d[p]   = wdata_s[gidx_s[p]];
        end else begin
          oeb_d[p] = 1'b0;
          ird_d[p] = 1'b1;
        end
      end else begin
      end
    end
  end

  // Issue stage registers drive the macro pins directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csb_q <= 2'b11;
      web_q <= 2'b11;
      oeb_q <= 2'b11;
      iv_q  <= 2'b00;
      ird_q <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        a_q[p]   <= '0;
        i_q[p]   <= '0;
        iid_q[p] <= '0;
      end
    end else begin
      csb_q <= csb_d;
      web_q <= web_d;
      oeb_q <= oeb_d;
      iv_q  <= iv_d;
      ird_q <= ird_d;
      for (int p = 0; p < 2; p++) begin
        a_q[p]   <= a_d[p];
        i_q[p]   <= i_d[p];
        iid_q[p] <= iid_d[p];
      end
    end
  end

  // Response stage: delay valid/read/id by the macro's one-edge read latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rv_q  <= 2'b00;
      rrd_q <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        rid_q[p] <= '0;
      end
    end else begin
      rv_q  <= iv_q;
      rrd_q <= ird_q;
      for (int p = 0; p < 2; p++) begin
        rid_q[p] <= iid_q[p];
      end
    end
  end

  // Route each port's macro output to the requester owning the pending read.
  always_comb begin
    rsp_valid_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      rdata_arr_s[i] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      if (rv_q[p] && rrd_q[p]) begin
        rsp_valid_s[rid_q[p]] = 1'b1;
        rdata_arr_s[rid_q[p]] = sram_o_s[p];
      end else begin
      end
    end
  end

  // Pack per-requester read data onto the flat response bus.
  always_comb begin
    rsp_rdata_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_rdata_s[i*DATA_W +: DATA_W] = rdata_arr_s[i];
    end
  end

  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_rdata = rsp_rdata_s;
  assign bus.sram_csb1 = csb_q[0];
  assign bus.sram_csb2 = csb_q[1];
  assign bus.sram_web1 = web_q[0];
  assign bus.sram_web2 = web_q[1];
  assign bus.sram_oeb1 = oeb_q[0];
  assign bus.sram_oeb2 = oeb_q[1];
  assign bus.sram_a1   = a_q[0];
  assign bus.sram_a2   = a_q[1];
  assign bus.sram_i1   = i_q[0];
  assign bus.sram_i2   = i_q[1];

endmodule

// File: tb/tb_sram2rw_arbiter.sv
// Self-checking bench for sram2rw_arbiter: table-driven grant/pin vectors,
// a behavioural 2RW macro, and a scoreboard for read responses.
module tb_sram2rw_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 24;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  always #5 clock = ~clock;

  sram2rw_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram2rw_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural macro: command and read data both registered at the sampling edge.
  logic [23:0] mem  [64] = '{default: 24'h0};
  logic [23:0] o1_q      = 24'h0;
  logic [23:0] o2_q      = 24'h0;

  assign bus.sram_o1 = o1_q;
  assign bus.sram_o2 = o2_q;

  always @(posedge clock) begin
    if (!bus.sram_csb1) begin
      if (!bus.sram_web1) mem[bus.sram_a1] <= bus.sram_i1;
      if (!bus.sram_oeb1) o1_q <= mem[bus.sram_a1];
    end
    if (!bus.sram_csb2) begin
      if (!bus.sram_web2) mem[bus.sram_a2] <= bus.sram_i2;
      if (!bus.sram_oeb2) o2_q <= mem[bus.sram_a2];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          id;
    logic [23:0] data;
  } rsp_t;

  rsp_t        sb_q [$];
  logic [23:0] ref_mem [64] = '{default: 24'h0};

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  we;
    logic [23:0] addr;   // {a3,a2,a1,a0}
    logic [95:0] wdata;  // {d3,d2,d1,d0}
    logic [3:0]  ready;  // expected req_ready
    logic [1:0]  csb;    // expected {csb2,csb1} after the edge
    logic [5:0]  a1;
    logic [5:0]  a2;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] we,
                              input logic [23:0] addr, input logic [95:0] wdata,
                              input logic [3:0] ready, input logic [1:0] csb,
                              input logic [5:0] a1, input logic [5:0] a2);
    vec_t v;
    v.valid = valid;
    v.we    = we;
    v.addr  = addr;
    v.wdata = wdata;
    v.ready = ready;
    v.csb   = csb;
    v.a1    = a1;
    v.a2    = a2;
    return v;
  endfunction

  // Response checker: every cycle compare rsp_valid/rdata with what is due now.
  always @(negedge clock) begin
    logic [3:0]  exp_mask;
    logic [23:0] exp_data [4];
    exp_mask = 4'b0000;
    for (int i = 0; i < 4; i++) exp_data[i] = 24'h0;
    while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      exp_mask[sb_q[0].id] = 1'b1;
      exp_data[sb_q[0].id] = sb_q[0].data;
      void'(sb_q.pop_front());
    end
    chk($sformatf("rsp_valid@%0d", cyc), bus.rsp_valid, exp_mask);
    for (int i = 0; i < 4; i++) begin
      if (exp_mask[i]) chk($sformatf("rsp_rdata%0d@%0d", i, cyc), bus.rsp_rdata[i*24 +: 24], exp_data[i]);
    end
  end

  // Drive one vector for one cycle, check grants and pins, update the model.
  task automatic apply(input vec_t v, input string tag);
    logic [5:0] a;
    @(negedge clock);
    bus.req_valid = v.valid;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    #1;
    chk({tag, "_ready"}, bus.req_ready, v.ready);
    @(posedge clock);
    #1;
    chk({tag, "_csb"}, {bus.sram_csb2, bus.sram_csb1}, v.csb);
    if (!v.csb[0]) chk({tag, "_a1"}, bus.sram_a1, v.a1);
    if (!v.csb[1]) chk({tag, "_a2"}, bus.sram_a2, v.a2);
    for (int i = 0; i < 4; i++) begin
      if (v.ready[i]) begin
        a = v.addr[i*6 +: 6];
        if (v.we[i]) ref_mem[a] = v.wdata[i*24 +: 24];
        else sb_q.push_back('{due: cyc + 1, id: i, data: ref_mem[a]});
      end
    end
  endtask

  initial begin
    bus.req_valid = 4'b0000;
    bus.req_we    = 4'b0000;
    bus.req_addr  = 24'h0;
    bus.req_wdata = 96'h0;

    // Reset state, with all requesters asking
    #1 reset_n = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_ctl", {bus.sram_csb2, bus.sram_csb1, bus.sram_web2, bus.sram_web1,
                    bus.sram_oeb2, bus.sram_oeb1}, 6'b111111);
    chk("rst_addr", {bus.sram_a2, bus.sram_a1}, 12'h0);
    chk("rst_wdata", {bus.sram_i2, bus.sram_i1}, 48'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
    chk("rst_ready", bus.req_ready, 4'b0000);
    repeat (2) @(negedge clock);
    reset_n       = 1'b1;
    bus.req_valid = 4'b0000;

    // v0-v1: write then read addr 5 (ptr 0 -> 1 -> 1)
    tbl.push_back(mk(4'b0001, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}, {24'h0, 24'h0, 24'h0, 24'hABCDEF}, 4'b0001, 2'b10, 6'd5, 6'd0));
    tbl.push_back(mk(4'b0001, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd5}, 96'h0, 4'b0001, 2'b10, 6'd5, 6'd0));
    // v2-v3: dual-port writes then dual-port reads, req1 on port 1, req2 on port 2
    tbl.push_back(mk(4'b0110, 4'b0110, {6'd0, 6'd60, 6'd3, 6'd0}, {24'h0, 24'h606060, 24'h333333, 24'h0}, 4'b0110, 2'b00, 6'd3, 6'd60));
    tbl.push_back(mk(4'b0110, 4'b0000, {6'd0, 6'd60, 6'd3, 6'd0}, 96'h0, 4'b0110, 2'b00, 6'd3, 6'd60));
    // v4: lone req3 brings ptr back to 0
    tbl.push_back(mk(4'b1000, 4'b0000, 24'h0, 96'h0, 4'b1000, 2'b10, 6'd0, 6'd0));
    // v5-v7: write/write conflict on addr 7, then read it back
    tbl.push_back(mk(4'b0011, 4'b0011, {6'd0, 6'd0, 6'd7, 6'd7}, {24'h0, 24'h0, 24'h222222, 24'h111111}, 4'b0001, 2'b10, 6'd7, 6'd0));
    tbl.push_back(mk(4'b0010, 4'b0010, {6'd0, 6'd0, 6'd7, 6'd0}, {24'h0, 24'h0, 24'h222222, 24'h0}, 4'b0010, 2'b10, 6'd7, 6'd0));
    tbl.push_back(mk(4'b0100, 4'b0000, {6'd0, 6'd7, 6'd0, 6'd0}, 96'h0, 4'b0100, 2'b10, 6'd7, 6'd0));
    // v8-v9: fill addr 9, then two reads of the same address in one cycle
    tbl.push_back(mk(4'b1000, 4'b1000, {6'd9, 6'd0, 6'd0, 6'd0}, {24'h999999, 24'h0, 24'h0, 24'h0}, 4'b1000, 2'b10, 6'd9, 6'd0));
    tbl.push_back(mk(4'b1100, 4'b0000, {6'd9, 6'd9, 6'd0, 6'd0}, 96'h0, 4'b1100, 2'b00, 6'd9, 6'd9));
    // v10-v13: fairness, all four reading continuously
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(4'b1111, 4'b0000, {6'd7, 6'd60, 6'd3, 6'd5}, 96'h0, 4'b0011, 2'b00, 6'd5, 6'd3));
      tbl.push_back(mk(4'b1111, 4'b0000, {6'd7, 6'd60, 6'd3, 6'd5}, 96'h0, 4'b1100, 2'b00, 6'd60, 6'd7));
    end
    // v14-v16: read/write conflict skips req1 but req2 still gets port 2
    tbl.push_back(mk(4'b0111, 4'b0010, {6'd0, 6'd3, 6'd3, 6'd3}, {24'h0, 24'h0, 24'h0A0A0A, 24'h0}, 4'b0101, 2'b00, 6'd3, 6'd3));
    tbl.push_back(mk(4'b0010, 4'b0010, {6'd0, 6'd0, 6'd3, 6'd0}, {24'h0, 24'h0, 24'h0A0A0A, 24'h0}, 4'b0010, 2'b10, 6'd3, 6'd0));
    tbl.push_back(mk(4'b0100, 4'b0000, {6'd0, 6'd3, 6'd0, 6'd0}, 96'h0, 4'b0100, 2'b10, 6'd3, 6'd0));
    // v17: idle cycle, both ports deselected, ptr holds at 3
    tbl.push_back(mk(4'b0000, 4'b0000, 24'h0, 96'h0, 4'b0000, 2'b11, 6'd0, 6'd0));
    // v18: scan wraps from 3 to 0
    tbl.push_back(mk(4'b1001, 4'b0000, {6'd60, 6'd0, 6'd0, 6'd5}, 96'h0, 4'b1001, 2'b00, 6'd60, 6'd5));

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n], $sformatf("v%0d", n));

    @(negedge clock);
    bus.req_valid = 4'b0000;
    repeat (4) @(negedge clock);

    // Reset one cycle after a read accept: command dropped, no response, ptr back to 0
    bus.req_valid = 4'b0001;
    bus.req_we    = 4'b0000;
    bus.req_addr  = {6'd0, 6'd0, 6'd0, 6'd5};
    #1;
    chk("mid_ready", bus.req_ready, 4'b0001);
    @(posedge clock);
    #1;
    chk("mid_csb_issue", {bus.sram_csb2, bus.sram_csb1}, 2'b10);
    @(negedge clock);
    reset_n       = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    chk("mid_csb_reset", {bus.sram_csb2, bus.sram_csb1}, 2'b11);
    chk("mid_oeb_reset", {bus.sram_oeb2, bus.sram_oeb1}, 2'b11);
    chk("mid_ready_reset", bus.req_ready, 4'b0000);
    repeat (2) @(negedge clock);
    reset_n       = 1'b1;
    bus.req_valid = 4'b0000;
    apply(mk(4'b1111, 4'b0000, {6'd7, 6'd60, 6'd3, 6'd5}, 96'h0, 4'b0011, 2'b00, 6'd5, 6'd3), "post_rst");

    @(negedge clock);
    bus.req_valid = 4'b0000;
    repeat (4) @(negedge clock);
    chk("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
